// File: rtl/key_expansion_block_pkg.sv
// Shared AES key-schedule types, constants and byte-level helpers.
// The S-box table is reused by the SubBytes stage through sub_word.
package key_expansion_block_pkg;

    localparam int SEED_KEY_WIDTH  = 128;
    localparam int ROUND_NUM_WIDTH = 4;
    localparam int NUM_ROUNDS      = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    // Entry 0 sits in the top byte, so the lookup index is inverted.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_expansion_block_sub_word.sv
// Combinational SubWord: four independent byte S-box lookups.
module sub_word
    import key_expansion_block_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    assign sub = {sbox(word[31:24]), sbox(word[23:16]),
                  sbox(word[15:8]),  sbox(word[7:0])};

endmodule

// File: rtl/key_expansion_block.sv
// AES-128 key schedule: latches a cipher key and emits round keys
// 0..10, advancing one round per valid/ready handshake.
module key_expansion_block
    import key_expansion_block_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SEED_KEY_WIDTH-1:0]  cipher_key,
    input  logic                       cipher_key_vld,
    input  logic                       round_key_rdy,
    output logic [SEED_KEY_WIDTH-1:0]  seed_key,
    output logic                       seed_key_vld,
    output logic [ROUND_NUM_WIDTH-1:0] round_num,
    output logic                       key_busy,
    output logic                       key_done
);

    localparam logic [ROUND_NUM_WIDTH-1:0] LAST_ROUND =
        ROUND_NUM_WIDTH'(NUM_ROUNDS);

    state_t                       state_q, state_d;
    logic [SEED_KEY_WIDTH-1:0]    key_q, key_d;
    logic [ROUND_NUM_WIDTH-1:0]   round_q, round_d;
    logic [7:0]                   rcon_q, rcon_d;
    logic                         done_q, done_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sw, t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_q;
    assign rot = {w3[23:0], w3[31:24]};

    sub_word u_sub_word (
        .word (rot),
        .sub  (sw)
    );

    assign t  = sw ^ {rcon_q, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= RCON_INIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cipher_key_vld) begin
                    key_d   = cipher_key;
                    round_d = '0;
                    rcon_d  = RCON_INIT;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (round_key_rdy) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        round_d = '0;
                        rcon_d  = RCON_INIT;
                    end else begin
                        key_d   = {n0, n1, n2, n3};
                        round_d = round_q + 1'b1;
                        rcon_d  = xtime(rcon_q);
                    end
                end
            end
        endcase
    end

    // Valid is the state flop itself; data is gated off while idle.
    assign seed_key_vld = (state_q == EMIT);
    assign seed_key     = seed_key_vld ? key_q : '0;
    assign round_num    = seed_key_vld ? round_q : '0;
    assign key_busy     = (state_q != IDLE);
    assign key_done     = done_q;

endmodule

// File: tb/tb_key_expansion_block.sv
// Scoreboard bench for key_expansion_block using known AES-128 vectors.
module tb_key_expansion_block;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] cipher_key;
    logic         cipher_key_vld;
    logic         round_key_rdy;
    logic [127:0] seed_key;
    logic         seed_key_vld;
    logic [3:0]   round_num;
    logic         key_busy;
    logic         key_done;

    key_expansion_block dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cipher_key     (cipher_key),
        .cipher_key_vld (cipher_key_vld),
        .round_key_rdy  (round_key_rdy),
        .seed_key       (seed_key),
        .seed_key_vld   (seed_key_vld),
        .round_num      (round_num),
        .key_busy       (key_busy),
        .key_done       (key_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
        bit           chk;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    localparam logic [127:0] KA = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] ka [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic [127:0] kz [0:2] = '{
        128'h00000000000000000000000000000000,
        128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa
    };

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_sched(input bit zero);
        exp_t e;
        for (int i = 0; i <= 10; i++) begin
            e.rnd = 4'(i);
            e.chk = zero ? (i <= 2) : 1'b1;
            e.key = zero ? ((i <= 2) ? kz[i] : '0) : ka[i];
            q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_round(input logic [3:0] r);
        int n = 0;
        while (!(seed_key_vld && round_num == r) && n < 200) begin
            tick();
            n++;
        end
        chk("wait_round_timeout", 128'(n < 200), 128'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!key_done && n < 200) begin
            tick();
            n++;
        end
        chk("wait_done_timeout", 128'(n < 200), 128'd1);
    endtask

    // Monitor: every valid cycle must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_done) done_cnt++;
            if (seed_key_vld) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: got round %0d expected none",
                             round_num);
                end else begin
                    chk("sb_round", 128'(round_num), 128'(q[0].rnd));
                    if (q[0].chk) chk("sb_key", seed_key, q[0].key);
                    if (round_key_rdy) void'(q.pop_front());
                end
            end else begin
                chk("idle_key", seed_key, '0);
                chk("idle_round", 128'(round_num), '0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int k;
        rst_n = 1'b0;
        cipher_key = '0;
        cipher_key_vld = 1'b0;
        round_key_rdy = 1'b0;
        repeat (3) tick();
        chk("rst_vld",  128'(seed_key_vld), '0);
        chk("rst_key",  seed_key, '0);
        chk("rst_round", 128'(round_num), '0);
        chk("rst_busy", 128'(key_busy), '0);
        chk("rst_done", 128'(key_done), '0);
        rst_n = 1'b1;
        tick();

        // Full-speed schedule with an ignored load at round 4
        d0 = done_cnt;
        round_key_rdy = 1'b1;
        cipher_key = KA;
        cipher_key_vld = 1'b1;
        push_sched(1'b0);
        tick();
        cipher_key_vld = 1'b0;
        chk("load_latency_vld", 128'(seed_key_vld), 128'd1);
        chk("load_latency_busy", 128'(key_busy), 128'd1);
        wait_round(4'd4);
        cipher_key = '0;
        cipher_key_vld = 1'b1;
        tick();
        cipher_key_vld = 1'b0;
        wait_done();
        chk("done_busy", 128'(key_busy), '0);
        chk("done_vld", 128'(seed_key_vld), '0);

        // Back-to-back load in the key_done cycle, then toggled ready
        cipher_key = KA;
        cipher_key_vld = 1'b1;
        push_sched(1'b0);
        tick();
        cipher_key_vld = 1'b0;
        chk("done_pulse_width", 128'(key_done), '0);
        chk("b2b_vld", 128'(seed_key_vld), 128'd1);
        chk("b2b_round", 128'(round_num), '0);
        k = 0;
        while (seed_key_vld && k < 60) begin
            tick();
            k++;
            round_key_rdy = ~round_key_rdy;
        end
        chk("toggle_span", 128'(k), 128'd21);
        round_key_rdy = 1'b1;
        tick();
        chk("done_count_ab", 128'(done_cnt - d0), 128'd2);
        chk("toggle_busy", 128'(key_busy), '0);

        // Ready held low for 50 cycles
        round_key_rdy = 1'b0;
        cipher_key = KA;
        cipher_key_vld = 1'b1;
        push_sched(1'b0);
        tick();
        cipher_key_vld = 1'b0;
        repeat (50) tick();
        chk("stall_busy", 128'(key_busy), 128'd1);
        chk("stall_round", 128'(round_num), '0);
        chk("stall_key", seed_key, KA);
        round_key_rdy = 1'b1;
        wait_done();
        tick();

        // Asynchronous reset in round 6, then the all-zero key
        cipher_key = KA;
        cipher_key_vld = 1'b1;
        push_sched(1'b0);
        tick();
        cipher_key_vld = 1'b0;
        wait_round(4'd6);
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("arst_vld", 128'(seed_key_vld), '0);
        chk("arst_key", seed_key, '0);
        chk("arst_round", 128'(round_num), '0);
        chk("arst_busy", 128'(key_busy), '0);
        d0 = done_cnt;
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (15) tick();
        chk("arst_no_done", 128'(done_cnt - d0), '0);
        cipher_key = '0;
        cipher_key_vld = 1'b1;
        push_sched(1'b1);
        tick();
        cipher_key_vld = 1'b0;
        wait_done();
        tick();
        chk("zero_done_count", 128'(done_cnt - d0), 128'd1);
        chk("queue_drained", 128'(q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_expansion_block.md
# key_expansion_block

AES-128 key-schedule stage. It sits directly upstream of the add-round-key stage and drives its `seed_key`/`seed_key_vld` inputs. It latches a 128-bit cipher key and emits round keys 0..10 in order, one per valid/ready handshake. It computes each next round key iteratively from the current one.

## Interface
- No parameters. Widths come from `chip_defines.v`: `SEED_KEY_WIDTH` = 128 and `ROUND_NUM_WIDTH` = 4.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Ports, clock and reset first:
  - `clk`  in  1  the single clock; all flops are rising-edge.
  - `rst_n`  in  1  asynchronous, active-low reset.
  - `cipher_key`  in  128  cipher key, sampled only on load.
  - `cipher_key_vld`  in  1  load request; honoured only in IDLE.
  - `round_key_rdy`  in  1  consumer ready; advances the schedule.
  - `seed_key`  out  128  current round key; zero when `seed_key_vld` is low.
  - `seed_key_vld`  out  1  round key valid.
  - `round_num`  out  4  index of the presented key, 0..10.
  - `key_busy`  out  1  high while the state is not IDLE.
  - `key_done`  out  1  one-cycle pulse after round-10 key is accepted.

## Operation
- State machine: IDLE and EMIT.
- IDLE:
  - If `cipher_key_vld` is high, load the key register with `cipher_key` and set round = 0, rcon = 8'h01. Next state is EMIT.
  - Otherwise remain in IDLE.
- EMIT:
  - Present `seed_key` = key register, `seed_key_vld` = 1 and `round_num` = round.
  - Handshake completes when `seed_key_vld` and `round_key_rdy` are both high.
  - On a handshake with round < 10: key register ← next_key(key register, rcon); round ← round + 1; rcon ← xtime(rcon).
  - On a handshake with round = 10: go to IDLE, pulse `key_done` on the following cycle, and clear round and rcon.
- next_key, with the key as words w0..w3 (w0 = bits [127:96]):
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
- xtime(r) = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00). This yields the rcon sequence 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- `cipher_key_vld` in EMIT is ignored; there is no restart and the key register is not disturbed.
- While `round_key_rdy` is low, all outputs stay stable.
- Reset values: `seed_key` = 0, `seed_key_vld` = 0, `round_num` = 0, `key_busy` = 0 and `key_done` = 0. State is IDLE, key register = 0, rcon = 8'h01.
- Reset asserted mid-schedule aborts immediately to these reset values; no `key_done` pulse follows.

## Timing
- Load at cycle N in IDLE → `seed_key_vld` = 1 with round 0 (the raw key) from cycle N+1.
- Handshake at cycle M → next key presented at M+1. Each key is a single-cycle registered update.
- With `round_key_rdy` held high, the full schedule is 11 consecutive valid cycles. `key_done` is high one cycle after the last of them.
- IDLE accepts a new load in the same cycle that `key_done` is high, so back-to-back keys run with a 1-cycle gap.
- `seed_key_vld` is a registered output; `seed_key` is a registered value gated to zero when not valid.
- `round_num` is registered and reads 0 when not valid.

## Structure
- Add `ROUND_NUM_WIDTH`, `NUM_ROUNDS` (10) and `RCON_INIT` (8'h01) to `chip_defines.v`, next to `BLOCK_DATA_WIDTH` and `SEED_KEY_WIDTH`.
- Sub-module `sub_word`: combinational, 32 bits in and out, containing four byte S-box lookups. It is reusable by the later SubBytes stage.
- The top contains the state machine, the key, round and rcon registers, and the next_key XOR chain.

## Test plan
- Reset, then load `cipher_key` = 2b7e151628aed2a6abf7158809cf4f3c with `round_key_rdy` = 1:
  - cycle 1: round 0 = the same value;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - `key_done` pulses once, then `key_busy` = 0.
- Same key with `round_key_rdy` toggling 1/0 every cycle → keys and `round_num` are identical to the previous case, each held stable while ready is low; 21 cycles from first valid to last valid.
- Pulse `cipher_key_vld` with key 000…0 at round 4 of the first key's schedule → ignored; rounds 5..10 still match the first key.
- Assert `rst_n` = 0 while round = 6 → all outputs 0 asynchronously and no `key_done`. After release, load the all-zero key → round 1 = 62636363626363636263636362636363.
- Load a second key in the same cycle as `key_done` → round 0 of the second key is valid on the next cycle.
- `round_key_rdy` held 0 for 50 cycles after load → round 0 stays presented, `round_num` = 0, `key_busy` = 1.
